sr_flag_bank: RTL and testbench
===============================

# sr_flag_bank

Parametrised bank of clocked set/reset flags, the synchronous multi-channel successor to the single SR latch. Each channel synchronises asynchronous set/clr requests, applies a configurable conflict-resolution mode and optional edge detection, and holds a sticky flag. A snapshot read port uses a valid/ready handshake with optional clear-on-read, and a masked interrupt output is provided. Sits between raw event sources and the control/status logic that polls or services them.

## Interface
- CHANNELS, 8, number of independent flag channels (1..32)
- SYNC_STAGES, 2, synchroniser depth on set/clr inputs (>=1)
- MODE, 0, simultaneous set+clr resolution: 0 reset-dominant, 1 set-dominant, 2 hold, 3 toggle
- EDGE, 0, 0 level-sensitive, 1 rising-edge-sensitive inputs
- CLEAR_ON_READ, 1, 1 clears captured flags when a snapshot is taken
---
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- set  in  CHANNELS  per-channel set request, asynchronous to clk
- clr  in  CHANNELS  per-channel clear request, asynchronous to clk
- irq_mask  in  CHANNELS  per-channel interrupt enable, synchronous
- rd_req  in  1  snapshot request, synchronous
- rd_ready  in  1  consumer accepts rd_data
- q  out  CHANNELS  flag state
- q_n  out  CHANNELS  bitwise complement of q, always
- rd_valid  out  1  rd_data holds a snapshot
- rd_data  out  CHANNELS  snapshot of q
- irq  out  1  OR of (q & irq_mask), registered

## Operation
- set/clr pass through SYNC_STAGES flops each; synchroniser flops reset to 0.
- EDGE=1: effective request = synced & ~previous synced sample; previous-sample flop resets to 0, so an input held high across reset release produces one event.
- EDGE=0: effective request = synced level.
- Per channel, per cycle, with s/c the effective requests:
  - s only: q<=1. c only: q<=0. neither: hold.
  - both: MODE0 q<=0, MODE1 q<=1, MODE2 hold, MODE3 q<=~q.
- Read handshake:
  - rd_req accepted when rd_valid=0, or rd_valid=1 and rd_ready=1 the same cycle (back-to-back).
  - On acceptance: rd_data<=q (pre-update value of this cycle), rd_valid<=1.
  - rd_valid=1 and rd_ready=0: rd_data, rd_valid held; rd_req ignored (not queued).
  - rd_ready=1 with no new accept: rd_valid<=0, rd_data retains last value.
  - CLEAR_ON_READ=1: on acceptance, channels with q=1 clear, except channels whose effective set result is 1 that cycle stay 1 (new event never lost). Effective clr/toggle still apply normally.
- irq <= |(q_next & irq_mask), registered.

## Timing
- Reset values: q=0, q_n=all ones, rd_valid=0, rd_data=0, irq=0, all internal flops 0.
- Reset assertion mid-handshake drops rd_valid immediately and discards the snapshot.
- Latency input edge -> q: SYNC_STAGES+1 cycles (EDGE adds no cycles). q -> irq: same cycle as q update (irq computed from next state).
- rd_req accept -> rd_valid high: 1 cycle. Clear-on-read takes effect in q the same edge rd_valid rises.
- Input pulses shorter than one clk period may be missed; the requirement is one clean clk-high sample.

## Test plan
- Reset: assert reset with set=0xFF held -> q=0x00, q_n=0xFF, irq=0, rd_valid=0 during reset; EDGE=1, release -> q=0xFF after SYNC_STAGES+1 cycles, exactly once.
- Latency: SYNC_STAGES=2, set[3] rises -> q[3]=1 on 3rd clk edge; irq=1 same edge if irq_mask[3]=1, stays 0 if mask=0.
- Conflict modes: set[0]=clr[0]=1 held 4 cycles from q=0 -> MODE0 q[0]=0, MODE1 1, MODE2 0, MODE3 level alternates 1,0,1,0 (EDGE=1 toggles once).
- Read: q=0xA5, rd_req one cycle, rd_ready=0 for 3 cycles -> rd_valid=1, rd_data=0xA5 stable, q=0x00 (CLEAR_ON_READ=1); extra rd_req ignored; rd_ready=1 -> rd_valid=0 next cycle.
- Read/set race: q[2]=1 and effective set[2]=1 on the accept cycle -> rd_data[2]=1 and q[2] remains 1.
- Back-to-back: rd_valid=1, rd_ready=1 and rd_req=1 same cycle with q=0x10 -> rd_valid stays 1, rd_data=0x10 next cycle.

Source files
------------

// File: rtl/sr_flag_bank_if.sv
// Event-flag bank bus: raw set/clr requests, interrupt mask,
// snapshot read handshake and flag/interrupt status.
interface sr_flag_bank_if #(
   parameter int CHANNELS = 8
);
   logic [CHANNELS-1:0] set;
   logic [CHANNELS-1:0] clr;
   logic [CHANNELS-1:0] irq_mask;
   logic                rd_req;
   logic                rd_ready;
   logic [CHANNELS-1:0] q;
   logic [CHANNELS-1:0] q_n;
   logic                rd_valid;
   logic [CHANNELS-1:0] rd_data;
   logic                irq;

   modport master (
      output set, clr, irq_mask, rd_req, rd_ready,
      input  q, q_n, rd_valid, rd_data, irq
   );

   modport slave (
      input  set, clr, irq_mask, rd_req, rd_ready,
      output q, q_n, rd_valid, rd_data, irq
   );
endinterface

// File: rtl/sr_flag_bank.sv
// Multi-channel sticky set/reset flags with synchronised inputs,
// conflict resolution, snapshot read port and masked interrupt.
module sr_flag_bank #(
   parameter int CHANNELS      = 8,
   parameter int SYNC_STAGES   = 2,
   parameter int MODE          = 0,
   parameter int EDGE          = 0,
   parameter int CLEAR_ON_READ = 1
) (
   input  logic           clk,
   input  logic           reset,
   sr_flag_bank_if.slave  bus
);

   typedef logic [CHANNELS-1:0] vec_t;

   logic [SYNC_STAGES-1:0][CHANNELS-1:0] set_sync_q;
   logic [SYNC_STAGES-1:0][CHANNELS-1:0] clr_sync_q;

   vec_t set_prev_q, clr_prev_q;
   vec_t q_q, q_d;
   vec_t rd_data_q, rd_data_d;
   logic rd_valid_q, rd_valid_d;
   logic irq_q, irq_d;

   vec_t set_syn, clr_syn;
   vec_t s_eff, c_eff;
   vec_t both, both_res, upd, set_win;
   logic accept;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         set_sync_q <= '0;
         clr_sync_q <= '0;
      end else begin
         set_sync_q[0] <= bus.set;
         clr_sync_q[0] <= bus.clr;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            set_sync_q[i] <= set_sync_q[i-1];
            clr_sync_q[i] <= clr_sync_q[i-1];
         end
      end
   end

   assign set_syn = set_sync_q[SYNC_STAGES-1];
   assign clr_syn = clr_sync_q[SYNC_STAGES-1];

   always_comb begin
      s_eff = set_syn;
      c_eff = clr_syn;
      if (EDGE != 0) begin
         s_eff = set_syn & ~set_prev_q;
         c_eff = clr_syn & ~clr_prev_q;
      end
   end

   // Resolution applied only where both requests land together
   always_comb begin
      both     = s_eff & c_eff;
      both_res = '0;
      set_win  = s_eff & ~c_eff;
      unique case (MODE)
         0:       both_res = '0;
         1: begin
            both_res = '1;
            set_win  = s_eff;
         end
         2:       both_res = q_q;
         default: both_res = ~q_q;
      endcase
      upd = (s_eff & ~c_eff)
          | (both & both_res)
          | (~s_eff & ~c_eff & q_q);
   end

   assign accept = bus.rd_req & (~rd_valid_q | bus.rd_ready);

   always_comb begin
      q_d        = upd;
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_valid_q;
      if (accept) begin
         rd_data_d  = q_q;
         rd_valid_d = 1'b1;
         // A set winning this cycle survives the clear-on-read
         if (CLEAR_ON_READ != 0)
            q_d = upd & (~q_q | set_win);
      end else if (bus.rd_ready) begin
         rd_valid_d = 1'b0;
      end
      irq_d = |(q_d & bus.irq_mask);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         set_prev_q <= '0;
         clr_prev_q <= '0;
         q_q        <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         set_prev_q <= set_syn;
         clr_prev_q <= clr_syn;
         q_q        <= q_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         irq_q      <= irq_d;
      end
   end

   assign bus.q        = q_q;
   assign bus.q_n      = ~q_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.irq      = irq_q;

endmodule

// File: tb/tb_sr_flag_bank.sv
// Directed bench: four level-sensitive instances (MODE 0..3) and
// one rising-edge MODE 3 instance share the same stimulus.
module tb_sr_flag_bank;

   localparam int N = 5;
   localparam int EI = 4;

   logic clk = 1'b0;
   logic reset;
   logic [7:0] set_r, clr_r, mask_r;
   logic rd_req_r, rd_ready_r;

   logic [7:0] q_w [N];
   logic [7:0] qn_w [N];
   logic [7:0] rdd_w [N];
   logic       rdv_w [N];
   logic       irq_w [N];

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   for (genvar m = 0; m < N; m++) begin : g
      sr_flag_bank_if #(.CHANNELS(8)) bus ();
      assign bus.set      = set_r;
      assign bus.clr      = clr_r;
      assign bus.irq_mask = mask_r;
      assign bus.rd_req   = rd_req_r;
      assign bus.rd_ready = rd_ready_r;
      sr_flag_bank #(
         .CHANNELS(8),
         .SYNC_STAGES(2),
         .MODE((m == EI) ? 3 : m),
         .EDGE((m == EI) ? 1 : 0),
         .CLEAR_ON_READ(1)
      ) dut (
         .clk(clk),
         .reset(reset),
         .bus(bus)
      );
      assign q_w[m]   = bus.q;
      assign qn_w[m]  = bus.q_n;
      assign rdd_w[m] = bus.rd_data;
      assign rdv_w[m] = bus.rd_valid;
      assign irq_w[m] = bus.irq;
   end

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_all();
      set_r = 8'h00;
      clr_r = 8'hFF;
      repeat (4) tick();
      clr_r = 8'h00;
      repeat (3) tick();
   endtask

   initial begin
      reset = 1'b1;
      set_r = 8'hFF;
      clr_r = 8'h00;
      mask_r = 8'h00;
      rd_req_r = 1'b0;
      rd_ready_r = 1'b0;
      repeat (3) tick();
      chk("rst_q", q_w[0], 8'h00);
      chk("rst_qn", qn_w[0], 8'hFF);
      chk("rst_irq", {7'd0, irq_w[0]}, 8'h00);
      chk("rst_rdv", {7'd0, rdv_w[0]}, 8'h00);
      chk("rst_rdd", rdd_w[0], 8'h00);
      chk("rst_q_edge", q_w[EI], 8'h00);

      // release with set held high
      reset = 1'b0;
      tick();
      tick();
      chk("rel_e2_edge", q_w[EI], 8'h00);
      tick();
      chk("rel_e3_edge", q_w[EI], 8'hFF);
      chk("rel_e3_lvl", q_w[0], 8'hFF);
      chk("rel_e3_qn", qn_w[0], 8'h00);
      clr_r = 8'hFF;
      tick();
      clr_r = 8'h00;
      tick();
      tick();
      chk("conf_m0", q_w[0], 8'h00);
      chk("conf_m1", q_w[1], 8'hFF);
      chk("once_edge_clr", q_w[EI], 8'h00);
      tick();
      chk("relevel_m0", q_w[0], 8'hFF);
      chk("once_edge", q_w[EI], 8'h00);
      clear_all();
      chk("clr_all", q_w[0], 8'h00);

      // latency and irq, masked in
      mask_r = 8'h08;
      set_r = 8'h08;
      tick();
      chk("lat_e1", q_w[0], 8'h00);
      tick();
      chk("lat_e2", q_w[0], 8'h00);
      chk("lat_e2_irq", {7'd0, irq_w[0]}, 8'h00);
      tick();
      chk("lat_e3", q_w[0], 8'h08);
      chk("lat_e3_irq", {7'd0, irq_w[0]}, 8'h01);
      clear_all();
      chk("irq_drop", {7'd0, irq_w[0]}, 8'h00);
      mask_r = 8'h00;
      set_r = 8'h08;
      repeat (3) tick();
      chk("lat_nm_q", q_w[0], 8'h08);
      chk("lat_nm_irq", {7'd0, irq_w[0]}, 8'h00);
      clear_all();

      // conflict modes, set[0]=clr[0]=1 for 4 cycles
      set_r = 8'h01;
      clr_r = 8'h01;
      tick();
      tick();
      tick();
      chk("tog_e3", q_w[3], 8'h01);
      chk("tog_e3_edge", q_w[EI], 8'h01);
      tick();
      chk("tog_e4", q_w[3], 8'h00);
      set_r = 8'h00;
      clr_r = 8'h00;
      tick();
      chk("tog_e5", q_w[3], 8'h01);
      tick();
      chk("mode0", q_w[0], 8'h00);
      chk("mode1", q_w[1], 8'h01);
      chk("mode2", q_w[2], 8'h00);
      chk("mode3", q_w[3], 8'h00);
      chk("mode3_edge", q_w[EI], 8'h01);
      tick();
      tick();
      chk("mode3_settle", q_w[3], 8'h00);
      chk("edge_settle", q_w[EI], 8'h01);
      clear_all();

      // snapshot with clear-on-read and stall
      set_r = 8'hA5;
      tick();
      set_r = 8'h00;
      repeat (4) tick();
      chk("rd_pre_q", q_w[0], 8'hA5);
      rd_req_r = 1'b1;
      tick();
      rd_req_r = 1'b0;
      chk("rd_acc_v", {7'd0, rdv_w[0]}, 8'h01);
      chk("rd_acc_d", rdd_w[0], 8'hA5);
      chk("rd_acc_q", q_w[0], 8'h00);
      set_r = 8'h3C;
      tick();
      set_r = 8'h00;
      chk("rd_hold1_v", {7'd0, rdv_w[0]}, 8'h01);
      tick();
      tick();
      chk("rd_hold_q", q_w[0], 8'h3C);
      chk("rd_hold_d", rdd_w[0], 8'hA5);
      rd_req_r = 1'b1;
      tick();
      rd_req_r = 1'b0;
      chk("rd_ign_d", rdd_w[0], 8'hA5);
      chk("rd_ign_q", q_w[0], 8'h3C);
      chk("rd_ign_v", {7'd0, rdv_w[0]}, 8'h01);
      rd_ready_r = 1'b1;
      tick();
      rd_ready_r = 1'b0;
      chk("rd_done_v", {7'd0, rdv_w[0]}, 8'h00);
      chk("rd_done_d", rdd_w[0], 8'hA5);

      // read racing a new set on channel 2
      set_r = 8'h04;
      tick();
      set_r = 8'h00;
      tick();
      rd_req_r = 1'b1;
      tick();
      rd_req_r = 1'b0;
      chk("race_d", rdd_w[0], 8'h3C);
      chk("race_q", q_w[0], 8'h04);
      chk("race_v", {7'd0, rdv_w[0]}, 8'h01);

      // back-to-back accept while holding a snapshot
      set_r = 8'h10;
      clr_r = 8'h04;
      tick();
      set_r = 8'h00;
      clr_r = 8'h00;
      tick();
      tick();
      chk("b2b_pre_q", q_w[0], 8'h10);
      chk("b2b_pre_d", rdd_w[0], 8'h3C);
      rd_req_r = 1'b1;
      rd_ready_r = 1'b1;
      tick();
      rd_req_r = 1'b0;
      chk("b2b_v", {7'd0, rdv_w[0]}, 8'h01);
      chk("b2b_d", rdd_w[0], 8'h10);
      chk("b2b_q", q_w[0], 8'h00);
      tick();
      rd_ready_r = 1'b0;
      chk("b2b_done_v", {7'd0, rdv_w[0]}, 8'h00);

      // reset in the middle of a held snapshot
      set_r = 8'h81;
      tick();
      set_r = 8'h00;
      repeat (3) tick();
      rd_req_r = 1'b1;
      tick();
      rd_req_r = 1'b0;
      chk("mid_v", {7'd0, rdv_w[0]}, 8'h01);
      chk("mid_d", rdd_w[0], 8'h81);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_v", {7'd0, rdv_w[0]}, 8'h00);
      chk("mid_rst_d", rdd_w[0], 8'h00);
      tick();
      reset = 1'b0;
      tick();
      chk("post_rst_q", q_w[0], 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
